// File: rtl/mux2_arb_pkg.sv
// Shared FSM state encoding for the two-source round-robin packet arbiter.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_A = 2'd1,
    GRANT_B = 2'd2
  } state_t;

endpackage

// File: rtl/mux2_sel.sv
// WIDTH-wide 2:1 select, combinational; B is chosen only when both selects are high.
module mux2_sel #(
  parameter int WIDTH = 8
) (
  input  logic             sel_b1,
  input  logic             sel_b2,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    if (sel_b1 && sel_b2) y = b;
    else                  y = a;
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Packet-locked round-robin merge of two streams; one-cycle registered output,
// one IDLE bubble per packet, source ready follows the output register's free slot.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             areset_n,
  input  logic             a_valid,
  input  logic             a_last,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic             b_last,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic             out_valid,
  output logic             out_last,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel_b1,
  output logic             sel_b2,
  output logic [CNT_W-1:0] pkt_count
);

  state_t           state;
  logic             ptr;
  logic             slot_free;
  logic             acc;
  logic             acc_last;
  logic [WIDTH-1:0] mux_data;
  logic             mux_last;

  assign slot_free = !out_valid || out_ready;
  assign a_ready   = (state == GRANT_A) && slot_free;
  assign b_ready   = (state == GRANT_B) && slot_free;
  assign sel_b1    = (state == GRANT_B);
  assign sel_b2    = (state == GRANT_B);

  mux2_sel #(.WIDTH(WIDTH + 1)) u_mux (
    .sel_b1 (sel_b1),
    .sel_b2 (sel_b2),
    .a      ({a_last, a_data}),
    .b      ({b_last, b_data}),
    .y      ({mux_last, mux_data})
  );

  assign acc      = (a_valid && a_ready) || (b_valid && b_ready);
  assign acc_last = acc && mux_last;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state     <= IDLE;
      ptr       <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_valid && (!b_valid || !ptr)) state <= GRANT_A;
          else if (b_valid)                  state <= GRANT_B;
        end
        GRANT_A, GRANT_B: begin
          // Grant is held through valid gaps; only an accepted last beat releases it.
          if (acc_last) begin
            state <= IDLE;
            ptr   <= (state == GRANT_A);
          end
        end
        default: state <= IDLE;
      endcase

      if (acc) begin
        out_valid <= 1'b1;
        out_data  <= mux_data;
        out_last  <= mux_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (acc_last) pkt_count <= pkt_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for the round-robin packet arbiter: queued source beats,
// expected output beats pushed on source acceptance and popped on output drain.
module tb_mux2_rr_arbiter;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          areset_n;
  logic          a_valid, a_last, b_valid, b_last;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready;
  logic          out_valid, out_last, out_ready;
  logic [W-1:0]  out_data;
  logic          sel_b1, sel_b2;
  logic [CW-1:0] pkt_count;

  mux2_rr_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .areset_n  (areset_n),
    .a_valid   (a_valid),
    .a_last    (a_last),
    .a_data    (a_data),
    .a_ready   (a_ready),
    .b_valid   (b_valid),
    .b_last    (b_last),
    .b_data    (b_data),
    .b_ready   (b_ready),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_data  (out_data),
    .out_ready (out_ready),
    .sel_b1    (sel_b1),
    .sel_b2    (sel_b2),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  logic [8:0]    a_q[$], b_q[$], exp_q[$];
  int            log_src[$], log_cyc[$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  logic [CW-1:0] exp_cnt = '0;
  bit            hs_a = 0, hs_b = 0;
  logic          pv = 0, pr = 0, pl = 0;
  logic [W-1:0]  pd = '0;
  logic [8:0]    e;

  int ar_t[6] = '{0, 1, 1, 1, 0, 0};
  int ov_t[6] = '{0, 0, 1, 1, 1, 0};
  int od_t[6] = '{0, 0, 'h11, 'h12, 'h13, 0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Source drivers update after the main process acts on the same edge.
  always begin
    @(posedge clk);
    #2;
    if (hs_a && a_q.size() > 0) void'(a_q.pop_front());
    if (hs_b && b_q.size() > 0) void'(b_q.pop_front());
    a_valid = (a_q.size() > 0);
    a_data  = a_valid ? a_q[0][7:0] : '0;
    a_last  = a_valid ? a_q[0][8]   : 1'b0;
    b_valid = (b_q.size() > 0);
    b_data  = b_valid ? b_q[0][7:0] : '0;
    b_last  = b_valid ? b_q[0][8]   : 1'b0;
  end

  // Handshakes sampled here complete at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (areset_n) begin
      chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("out_beat", {out_last, out_data}, e);
        end
      end
      if (pv && !pr) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_last", out_last, pl);
      end
      if (out_valid && !out_ready) chk("ready_stall", {a_ready, b_ready}, 0);
      if (a_valid && a_ready) begin
        exp_q.push_back({a_last, a_data});
        log_src.push_back(0);
        log_cyc.push_back(cyc);
        chk("sel_a", {sel_b1, sel_b2}, 0);
        if (a_last) exp_cnt++;
      end
      if (b_valid && b_ready) begin
        exp_q.push_back({b_last, b_data});
        log_src.push_back(1);
        log_cyc.push_back(cyc);
        chk("sel_b", {sel_b1, sel_b2}, 3);
        if (b_last) exp_cnt++;
      end
      hs_a = a_valid && a_ready;
      hs_b = b_valid && b_ready;
      pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
    end else begin
      hs_a = 0; hs_b = 0; pv = 0;
    end
  end

  task automatic reset_on();
    @(posedge clk);
    #1;
    areset_n = 1'b0;
    a_q.delete(); b_q.delete(); exp_q.delete();
    log_src.delete(); log_cyc.delete();
    exp_cnt = '0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic reset_off();
    @(posedge clk);
    #1;
    areset_n = 1'b1;
  endtask

  task automatic push_pkt(input int src, input int n, input int base);
    for (int i = 0; i < n; i++) begin
      if (src == 0) a_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, 8'(base + i)});
      else          b_q.push_back({(i == n - 1) ? 1'b1 : 1'b0, 8'(base + i)});
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((a_q.size() > 0 || b_q.size() > 0 || exp_q.size() > 0 || out_valid) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= budget) chk("timeout", 1, 0);
    @(negedge clk);
  endtask

  initial begin
    int found;
    areset_n = 1'b0; out_ready = 1'b1;
    a_valid = 0; a_last = 0; a_data = '0;
    b_valid = 0; b_last = 0; b_data = '0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ready", {a_ready, b_ready}, 0);
    chk("rst_sel", {sel_b1, sel_b2}, 0);
    chk("rst_cnt", 32'(pkt_count), 0);

    // Single 3-beat A packet, cycle-exact.
    reset_on();
    push_pkt(0, 3, 'h11);
    reset_off();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk($sformatf("t1_a_ready_%0d", k), a_ready, ar_t[k]);
      chk($sformatf("t1_out_valid_%0d", k), out_valid, ov_t[k]);
      if (k >= 2 && k <= 4) chk($sformatf("t1_out_data_%0d", k), out_data, od_t[k]);
    end
    chk("t1_cnt", 32'(pkt_count), 1);

    // Both sources always valid: A,B,A,B from a reset pointer.
    reset_on();
    push_pkt(0, 1, 'hA1); push_pkt(0, 1, 'hA2);
    push_pkt(1, 1, 'hB1); push_pkt(1, 1, 'hB2);
    reset_off();
    wait_idle(100);
    chk("t2_ngrants", log_src.size(), 4);
    for (int i = 0; i < 4 && i < log_src.size(); i++)
      chk($sformatf("t2_grant_%0d", i), log_src[i], i % 2);
    chk("t2_cnt", 32'(pkt_count), 4);

    // Output stall mid-packet.
    push_pkt(0, 4, 'h40);
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_stall_valid", out_valid, 1);
    chk("t3_stall_a_ready", a_ready, 0);
    repeat (3) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    wait_idle(100);
    chk("t3_cnt", 32'(pkt_count), 5);

    // B arrives during an A packet: waits for A's last beat plus one IDLE cycle.
    log_src.delete(); log_cyc.delete();
    push_pkt(0, 3, 'h60);
    repeat (2) begin @(posedge clk); #1; end
    push_pkt(1, 2, 'h70);
    wait_idle(100);
    chk("t4_nbeats", log_src.size(), 5);
    if (log_src.size() == 5) begin
      chk("t4_src", {log_src[0][0], log_src[1][0], log_src[2][0], log_src[3][0], log_src[4][0]}, 5'b00011);
      chk("t4_bubble", log_cyc[3] - log_cyc[2], 2);
    end

    // Reset during beat 2 of a 4-beat B packet, with the pointer left at B.
    push_pkt(0, 1, 'h80);
    wait_idle(100);
    log_src.delete(); log_cyc.delete();
    push_pkt(1, 4, 'h90);
    found = 0;
    for (int n = 0; n < 50 && !found; n++) begin
      @(posedge clk);
      #1;
      if (log_src.size() > 0) found = 1;
    end
    chk("t5_b_started", found, 1);
    areset_n = 1'b0;
    #1;
    chk("t5_out_valid", out_valid, 0);
    chk("t5_out_data", out_data, 0);
    chk("t5_out_last", out_last, 0);
    chk("t5_cnt", 32'(pkt_count), 0);
    chk("t5_ready", {a_ready, b_ready}, 0);
    chk("t5_sel", {sel_b1, sel_b2}, 0);
    a_q.delete(); b_q.delete(); exp_q.delete();
    log_src.delete(); log_cyc.delete();
    exp_cnt = '0;
    repeat (2) begin @(posedge clk); #1; end
    push_pkt(0, 3, 'hC0);
    push_pkt(1, 1, 'hD0);
    reset_off();
    wait_idle(100);
    chk("t5_nbeats", log_src.size(), 4);
    if (log_src.size() == 4)
      chk("t5_order", {log_src[0][0], log_src[1][0], log_src[2][0], log_src[3][0]}, 4'b0001);
    chk("t5_cnt_after", 32'(pkt_count), 2);

    // 17 packets wrap the 4-bit counter to 1.
    reset_on();
    reset_off();
    for (int i = 0; i < 17; i++) push_pkt(0, 1, i);
    wait_idle(200);
    chk("t6_wrap", 32'(pkt_count), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
